// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT memory sequencer slice.
//   FFT_ADDR_W / FFT_DATA_W : default SRAM geometry (256 x 128)
//   fft_seq_state_t         : sequencer state encoding
//   fft_cfg_t               : engine configuration latched on an accepted start
package fft_pkg;

    localparam int unsigned FFT_ADDR_W = 8;
    localparam int unsigned FFT_DATA_W = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } fft_seq_state_t;

    typedef struct packed {
        logic [2:0]  point;
        logic [10:0] cycles;
    } fft_cfg_t;

endpackage

// File: rtl/fft_sram_port_mux.sv
// fft_sram_port_mux: combinational source select for the dual-port FFT SRAM.
//   sel_host_i / sel_engine_i : which side owns the ports (neither -> all zero)
//   host_rd_i / host_wr_i     : accepted host read / write this cycle
//   host_addr_i, host_wdata_i : host request
//   eng_*_i                   : engine port requests, passed through when selected
//   sram_*_o                  : SRAM port drive; unused fields are held at zero
module fft_sram_port_mux #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              sel_host_i,
    input  logic              sel_engine_i,
    input  logic              host_rd_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic [ADDR_W-1:0] eng_raddr1_i,
    input  logic [ADDR_W-1:0] eng_raddr2_i,
    input  logic [ADDR_W-1:0] eng_waddr1_i,
    input  logic [ADDR_W-1:0] eng_waddr2_i,
    input  logic [DATA_W-1:0] eng_wdata1_i,
    input  logic [DATA_W-1:0] eng_wdata2_i,
    input  logic              eng_we_i,
    output logic [ADDR_W-1:0] sram_raddr1_o,
    output logic [ADDR_W-1:0] sram_raddr2_o,
    output logic [ADDR_W-1:0] sram_waddr1_o,
    output logic [ADDR_W-1:0] sram_waddr2_o,
    output logic [DATA_W-1:0] sram_wdata1_o,
    output logic [DATA_W-1:0] sram_wdata2_o,
    output logic              sram_we_o
);

    always_comb begin
        sram_raddr1_o = '0;
        sram_raddr2_o = '0;
        sram_waddr1_o = '0;
        sram_waddr2_o = '0;
        sram_wdata1_o = '0;
        sram_wdata2_o = '0;
        sram_we_o     = 1'b0;
        if (sel_engine_i) begin
            sram_raddr1_o = eng_raddr1_i;
            sram_raddr2_o = eng_raddr2_i;
            sram_waddr1_o = eng_waddr1_i;
            sram_waddr2_o = eng_waddr2_i;
            sram_wdata1_o = eng_wdata1_i;
            sram_wdata2_o = eng_wdata2_i;
            sram_we_o     = eng_we_i;
        end else if (sel_host_i) begin
            if (host_rd_i) begin
                sram_raddr1_o = host_addr_i;
            end
            // Both write ports get the same word; the duplicate write is harmless.
            if (host_wr_i) begin
                sram_we_o     = 1'b1;
                sram_waddr1_o = host_addr_i;
                sram_waddr2_o = host_addr_i;
                sram_wdata1_o = host_wdata_i;
                sram_wdata2_o = host_wdata_i;
            end
        end
    end

endmodule

// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: owns the FFT working SRAM. In idle the host gets single-word
// read/write access; a start hands both SRAM ports to fft_top until it reports done
// or the watchdog expires, followed by a two-cycle drain before returning to the host.
//   clk, rst                         : clock, synchronous active-high reset
//   host_*                           : host word access (1-cycle read latency)
//   start, cfg_point, cfg_cycles     : run request and its configuration
//   busy, done, timeout, run_cycles  : status (done/timeout sticky until next start)
//   fft_*                            : engine control, handshake and SRAM requests
//   sram_*                           : SRAM ports (read data has 1-cycle latency)
module fft_mem_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned ADDR_W         = FFT_ADDR_W,
    parameter int unsigned DATA_W         = FFT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              start,
    input  logic [2:0]        cfg_point,
    input  logic [10:0]       cfg_cycles,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       run_cycles,
    output logic              fft_working,
    output logic [2:0]        fft_point_config,
    output logic [10:0]       fft_cycle_count,
    input  logic              fft_done,
    input  logic [ADDR_W-1:0] fft_raddr1,
    input  logic [ADDR_W-1:0] fft_raddr2,
    input  logic [ADDR_W-1:0] fft_waddr1,
    input  logic [ADDR_W-1:0] fft_waddr2,
    input  logic [DATA_W-1:0] fft_wdata1,
    input  logic [DATA_W-1:0] fft_wdata2,
    input  logic              fft_we,
    output logic [DATA_W-1:0] fft_rdata1,
    output logic [DATA_W-1:0] fft_rdata2,
    output logic [ADDR_W-1:0] sram_raddr1,
    output logic [ADDR_W-1:0] sram_raddr2,
    output logic [ADDR_W-1:0] sram_waddr1,
    output logic [ADDR_W-1:0] sram_waddr2,
    output logic [DATA_W-1:0] sram_wdata1,
    output logic [DATA_W-1:0] sram_wdata2,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata1,
    input  logic [DATA_W-1:0] sram_rdata2
);

    localparam logic [1:0] ST_IDLE  = StIdle;
    localparam logic [1:0] ST_RUN   = StRun;
    localparam logic [1:0] ST_DRAIN = StDrain;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic        drain_last_q, drain_last_d;
    fft_cfg_t    cfg_q, cfg_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic        host_rvalid_q, host_rvalid_d;

    logic        in_idle;
    logic        host_acc;
    logic        start_acc;
    logic [15:0] run_inc;

    assign in_idle    = (state_q == ST_IDLE);
    // Start has priority over a host request in the same cycle.
    assign host_ready = in_idle && !start;
    assign host_acc   = host_valid && host_ready;
    assign start_acc  = start && in_idle;
    // Count including the current RUN cycle, saturating.
    assign run_inc    = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        drain_last_d  = drain_last_q;
        cfg_d         = cfg_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        run_cycles_d  = run_cycles_q;
        host_rvalid_d = host_acc && !host_we;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    cfg_d.point  = cfg_point;
                    cfg_d.cycles = cfg_cycles;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    run_cycles_d = '0;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                run_cycles_d = run_inc;
                if (fft_done) begin
                    done_d       = 1'b1;
                    drain_last_d = 1'b0;
                    state_d      = ST_DRAIN;
                end else if (run_inc == TIMEOUT_LIMIT) begin
                    timeout_d    = 1'b1;
                    drain_last_d = 1'b0;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_last_d = 1'b1;
                if (drain_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            drain_last_q  <= 1'b0;
            cfg_q         <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            run_cycles_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_last_q  <= drain_last_d;
            cfg_q         <= cfg_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            run_cycles_q  <= run_cycles_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign busy             = !in_idle;
    assign fft_working      = (state_q == ST_RUN);
    assign done             = done_q;
    assign timeout          = timeout_q;
    assign run_cycles       = run_cycles_q;
    assign fft_point_config = cfg_q.point;
    assign fft_cycle_count  = cfg_q.cycles;
    assign host_rvalid      = host_rvalid_q;
    assign host_rdata       = host_rvalid_q ? sram_rdata1 : '0;
    // Drain still forwards data for reads the engine issued in its last RUN cycle.
    assign fft_rdata1       = in_idle ? '0 : sram_rdata1;
    assign fft_rdata2       = in_idle ? '0 : sram_rdata2;

    fft_sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .sel_host_i    (in_idle),
        .sel_engine_i  (fft_working),
        .host_rd_i     (host_acc && !host_we),
        .host_wr_i     (host_acc && host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .eng_raddr1_i  (fft_raddr1),
        .eng_raddr2_i  (fft_raddr2),
        .eng_waddr1_i  (fft_waddr1),
        .eng_waddr2_i  (fft_waddr2),
        .eng_wdata1_i  (fft_wdata1),
        .eng_wdata2_i  (fft_wdata2),
        .eng_we_i      (fft_we),
        .sram_raddr1_o (sram_raddr1),
        .sram_raddr2_o (sram_raddr2),
        .sram_waddr1_o (sram_waddr1),
        .sram_waddr2_o (sram_waddr2),
        .sram_wdata1_o (sram_wdata1),
        .sram_wdata2_o (sram_wdata2),
        .sram_we_o     (sram_we)
    );

endmodule
